clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter W, default 28: counter/divisor width in bits.
REQ-003 Parameter DIV_DEFAULT, default 470: per-channel divisor after reset.
REQ-004 Parameter HIGH_DEFAULT, default 235: per-channel high-phase length after reset.
REQ-005 clock_in  input  1  sole clock; all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  NCH  per-channel run enable.
REQ-008 cfg_valid  input  1  configuration write strobe, single cycle.
REQ-009 cfg_ch  input  clog2(NCH) (min 1)  target channel.
REQ-010 cfg_div  input  W  requested divisor.
REQ-011 cfg_high  input  W  requested high-phase cycles.
REQ-012 cfg_ack  output  1  one-cycle pulse, write accepted.
REQ-013 cfg_err  output  1  one-cycle pulse, write rejected.
REQ-014 cfg_pending  output  NCH  channel holds a staged, not yet applied configuration.
REQ-015 clock_out  output  NCH  divided clocks.
REQ-016 tick  output  NCH  one-cycle pulse at start of each output period.

Function
REQ-017 Each channel SHALL hold an active (div, high) pair, a shadow pair, and counter cnt, range 0..div-1.
REQ-018 Enabled channel: cnt SHALL advance by 1 per cycle and wrap to 0 when cnt >= div-1.
REQ-019 clock_out[c] SHALL be registered: value in cycle t+1 = en[c] && (cnt[c](t) < high[c]); period = div cycles, high for exactly high cycles.
REQ-020 tick[c] SHALL be registered: high in cycle t+1 iff en[c] && cnt[c](t) == 0.
REQ-021 Disabled channel: cnt SHALL be held at 0; clock_out and tick SHALL be 0 from the next cycle.
REQ-022 en[c] 0->1 SHALL start counting from cnt=0; first tick and first clock_out high one cycle after the first enabled cycle.
REQ-023 A write is legal iff cfg_ch < NCH, cfg_div >= 2, and 1 <= cfg_high <= cfg_div-1.
REQ-024 Legal write: cfg_ack SHALL pulse the next cycle; values go to the shadow of cfg_ch; cfg_pending[cfg_ch] set.
REQ-025 Illegal write: cfg_err SHALL pulse the next cycle; no state changes.
REQ-026 Enabled channel: shadow SHALL be copied to active in the cycle cnt wraps (cnt >= div-1), so the next period starts with new values; pending cleared the same edge.
REQ-027 Disabled channel: shadow SHALL be applied on the edge following the write; pending cleared at that edge.
REQ-028 Second write to a pending channel before application SHALL overwrite the shadow; only the latest values are applied.
REQ-029 Write landing on the wrap cycle of its channel SHALL be staged and applied at the following wrap, not the current one.
REQ-030 Changing div/high never SHALL produce a truncated period or glitch: the current period always completes with the old values.
REQ-031 Comparisons and counter arithmetic SHALL be unsigned W bits; no overflow is possible given REQ-023.
REQ-032 cfg_ack and cfg_err SHALL never be asserted together.

Reset
REQ-033 reset_n low SHALL immediately force: cnt=0, active and shadow = (DIV_DEFAULT, HIGH_DEFAULT), cfg_pending=0, clock_out=0, tick=0, cfg_ack=0, cfg_err=0.
REQ-034 Reset mid-operation SHALL discard staged writes; after release, enabled channels restart per REQ-022 with default values.
REQ-035 Parameters SHALL satisfy 2 <= DIV_DEFAULT < 2^W and 1 <= HIGH_DEFAULT <= DIV_DEFAULT-1.

Verification
REQ-036 Reset release, en=1 on ch0, defaults -> clock_out[0] period 470, high 235 cycles, tick every 470 cycles.
REQ-037 Write ch1 div=10 high=3 while enabled mid-period -> ack next cycle, pending=1 until wrap, old period completes, then period 10 with 3 high.
REQ-038 Writes div=1, div=8 high=8, div=8 high=0, cfg_ch>=NCH -> cfg_err each, no ack, outputs unchanged.
REQ-039 Two writes to ch2 (div=6, then div=12 high=4) before wrap -> only div=12 high=4 applied at wrap.
REQ-040 Drop en[3] mid-period, write div=4 high=2, re-enable -> clock_out 0 while disabled, restart 1,1,0,0 repeating, tick at each period start.
REQ-041 Assert reset_n low with a pending write -> all outputs 0 immediately; after release defaults active, pending=0.

Source files
------------

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with per-channel shadowed (div, high) configuration.
// Staged values take effect only on a period boundary, or on the next edge when the channel is idle.
module clk_div_prog #(
   parameter int NCH          = 4,
   parameter int W            = 28,
   parameter int DIV_DEFAULT  = 470,
   parameter int HIGH_DEFAULT = 235,
   localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic [NCH-1:0]   en,
   input  logic             cfg_valid,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [W-1:0]     cfg_div,
   input  logic [W-1:0]     cfg_high,
   output logic             cfg_ack,
   output logic             cfg_err,
   output logic [NCH-1:0]   cfg_pending,
   output logic [NCH-1:0]   clock_out,
   output logic [NCH-1:0]   tick
);

   // cfg_valid is a single-cycle strobe with no ready: every strobe is answered on the
   // following cycle by exactly one of cfg_ack (staged) or cfg_err (dropped, nothing changes).

   logic [W-1:0]   cnt    [NCH];
   logic [W-1:0]   div_a  [NCH];
   logic [W-1:0]   high_a [NCH];
   logic [W-1:0]   div_s  [NCH];
   logic [W-1:0]   high_s [NCH];
   logic [NCH-1:0] wrap;
   logic [NCH-1:0] hit;
   logic           legal;

   always_comb begin
      legal = (32'(cfg_ch) < 32'(NCH)) &&
              (cfg_div >= W'(2)) &&
              (cfg_high >= W'(1)) &&
              (cfg_high <= cfg_div - W'(1));
   end

   // hit: this cycle's write targets channel c; it takes priority over applying the old shadow
   always_comb begin
      wrap = '0;
      hit  = '0;
      for (int c = 0; c < NCH; c++) begin
         wrap[c] = (cnt[c] >= div_a[c] - W'(1));
         hit[c]  = cfg_valid && legal && (32'(cfg_ch) == 32'(c));
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cfg_ack     <= 1'b0;
         cfg_err     <= 1'b0;
         cfg_pending <= '0;
         clock_out   <= '0;
         tick        <= '0;
         for (int c = 0; c < NCH; c++) begin
            cnt[c]    <= '0;
            div_a[c]  <= W'(DIV_DEFAULT);
            high_a[c] <= W'(HIGH_DEFAULT);
            div_s[c]  <= W'(DIV_DEFAULT);
            high_s[c] <= W'(HIGH_DEFAULT);
         end
      end else begin
         cfg_ack <= cfg_valid && legal;
         cfg_err <= cfg_valid && !legal;
         for (int c = 0; c < NCH; c++) begin
            if (en[c]) begin
               cnt[c]       <= wrap[c] ? '0 : cnt[c] + W'(1);
               clock_out[c] <= (cnt[c] < high_a[c]);
               tick[c]      <= (cnt[c] == '0);
            end else begin
               cnt[c]       <= '0;
               clock_out[c] <= 1'b0;
               tick[c]      <= 1'b0;
            end

            // A write on the wrap cycle is only staged, so the following period keeps the old values
            if (hit[c]) begin
               div_s[c]       <= cfg_div;
               high_s[c]      <= cfg_high;
               cfg_pending[c] <= 1'b1;
            end else if (cfg_pending[c] && (!en[c] || wrap[c])) begin
               div_a[c]       <= div_s[c];
               high_a[c]      <= high_s[c];
               cfg_pending[c] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized + directed bench for clk_div_prog: a period-position reference model pushes
// expected outputs per cycle into exp_q, and a monitor pops and compares after each edge.
module tb_clk_div_prog;

   localparam int NCH = 5;
   localparam int W   = 28;
   localparam int DD  = 470;
   localparam int HD  = 235;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int EW  = 2 + 3 * NCH;

   logic             clock_in;
   logic             reset_n;
   logic [NCH-1:0]   en;
   logic             cfg_valid;
   logic [CHW-1:0]   cfg_ch;
   logic [W-1:0]     cfg_div;
   logic [W-1:0]     cfg_high;
   logic             cfg_ack;
   logic             cfg_err;
   logic [NCH-1:0]   cfg_pending;
   logic [NCH-1:0]   clock_out;
   logic [NCH-1:0]   tick;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];

   // stimulus-side state
   logic           rst_drv;
   logic [NCH-1:0] en_drv;
   int unsigned    cyc;

   // reference model: active/shadow values and the cycle at which the current period began
   int unsigned m_adiv  [NCH];
   int unsigned m_ahigh [NCH];
   int unsigned m_sdiv  [NCH];
   int unsigned m_shigh [NCH];
   int unsigned m_start [NCH];
   bit          m_pend  [NCH];
   bit          m_was_en[NCH];

   clk_div_prog #(
      .NCH(NCH), .W(W), .DIV_DEFAULT(DD), .HIGH_DEFAULT(HD)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_high   (cfg_high),
      .cfg_ack    (cfg_ack),
      .cfg_err    (cfg_err),
      .cfg_pending(cfg_pending),
      .clock_out  (clock_out),
      .tick       (tick)
   );

   // clock / reset
   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   function automatic logic [EW-1:0] model_step(input bit v, input int ch, input int dv, input int hi);
      logic [NCH-1:0] ck, tk, pd;
      bit legal, wr, last;
      int unsigned phase;
      ck = '0;
      tk = '0;
      pd = '0;
      if (!rst_drv) begin
         for (int c = 0; c < NCH; c++) begin
            m_adiv[c] = DD;  m_ahigh[c] = HD;
            m_sdiv[c] = DD;  m_shigh[c] = HD;
            m_pend[c] = 0;   m_was_en[c] = 0;  m_start[c] = 0;
         end
         return '0;
      end
      legal = v && (ch < NCH) && (dv >= 2) && (hi >= 1) && (hi <= dv - 1);
      for (int c = 0; c < NCH; c++) begin
         wr   = legal && (ch == c);
         last = 0;
         if (en_drv[c]) begin
            if (!m_was_en[c]) m_start[c] = cyc;
            phase = cyc - m_start[c];
            ck[c] = (phase < m_ahigh[c]);
            tk[c] = (phase == 0);
            last  = (phase == m_adiv[c] - 1);
            if (last) m_start[c] = cyc + 1;
         end
         m_was_en[c] = en_drv[c];
         if (wr) begin
            m_sdiv[c]  = dv;
            m_shigh[c] = hi;
            m_pend[c]  = 1;
         end else if (m_pend[c] && (!en_drv[c] || last)) begin
            m_adiv[c]  = m_sdiv[c];
            m_ahigh[c] = m_shigh[c];
            m_pend[c]  = 0;
         end
         pd[c] = m_pend[c];
      end
      return {legal, v && !legal, pd, ck, tk};
   endfunction

   // driver tasks
   task automatic step(input bit v, input int ch, input int dv, input int hi);
      @(negedge clock_in);
      reset_n   = rst_drv;
      en        = en_drv;
      cfg_valid = v;
      cfg_ch    = CHW'(ch);
      cfg_div   = W'(dv);
      cfg_high  = W'(hi);
      exp_q.push_back(model_step(v, ch, dv, hi));
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic wr(input int ch, input int dv, input int hi);
      step(1, ch, dv, hi);
   endtask

   task automatic assert_reset_now();
      logic [EW-1:0] act;
      @(negedge clock_in);
      rst_drv   = 1'b0;
      reset_n   = 1'b0;
      cfg_valid = 1'b0;
      #1;
      act = {cfg_ack, cfg_err, cfg_pending, clock_out, tick};
      checks++;
      if (act !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs got=%b want=0", act);
      end
   endtask

   // scoreboard monitor
   always @(posedge clock_in) begin
      logic [EW-1:0] e, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {cfg_ack, cfg_err, cfg_pending, clock_out, tick};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t ack/err/pend/clk/tick got=%b/%b/%b/%b/%b want=%b/%b/%b/%b/%b",
                     $time, a[EW-1], a[EW-2], a[3*NCH-1:2*NCH], a[2*NCH-1:NCH], a[NCH-1:0],
                     e[EW-1], e[EW-2], e[3*NCH-1:2*NCH], e[2*NCH-1:NCH], e[NCH-1:0]);
         end
      end
   end

   initial begin
      int dv, hi, ch, idx;
      reset_n   = 1'b0;
      rst_drv   = 1'b0;
      en        = '0;
      en_drv    = '0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_high  = '0;
      cyc       = 0;

      idle(3);
      rst_drv = 1'b1;

      // defaults on ch0: two full 470-cycle periods
      en_drv = 5'b00001;
      idle(2 * DD + 5);

      // all channels running, ch1 reprogrammed mid-period
      en_drv = '1;
      idle(37);
      wr(1, 10, 3);
      idle(DD + 30);

      // illegal writes
      wr(0, 1, 1);
      wr(0, 8, 8);
      wr(0, 8, 0);
      wr(5, 10, 3);
      wr(7, 10, 3);
      idle(5);

      // two writes to ch2 before its wrap: only the second is applied
      idle(17);
      wr(2, 6, 3);
      idle(4);
      wr(2, 12, 4);
      idle(DD + 40);

      // ch3 disabled, reprogrammed, re-enabled
      idle(7);
      en_drv[3] = 1'b0;
      idle(3);
      wr(3, 4, 2);
      idle(5);
      en_drv[3] = 1'b1;
      idle(20);

      // randomized traffic, including illegal writes and enable toggles
      for (int i = 0; i < NCH; i++) wr(i, $urandom_range(2, 12), 1);
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            idx = $urandom_range(0, NCH - 1);
            en_drv[idx] = ~en_drv[idx];
         end
         if ($urandom_range(0, 5) == 0) begin
            dv = $urandom_range(0, 20);
            hi = $urandom_range(0, dv + 1);
            ch = $urandom_range(0, 7);
            step(1, ch, dv, hi);
         end else begin
            idle(1);
         end
      end

      // reset with a staged write outstanding
      en_drv = '1;
      idle(3);
      wr(0, 8, 3);
      assert_reset_now();
      idle(3);
      rst_drv = 1'b1;
      idle(DD + 10);

      @(posedge clock_in);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
